// File: rtl/id_bypass_stage_pkg.sv
// Shared constants for the decode bypass stage: default widths and producer port indices.
// Bypass mode is selected by the ID_BYPASS_EN macro (see id_fwd_mux).
package id_bypass_stage_pkg;
  localparam int XLEN_DEF      = 32;
  localparam int AW_DEF        = 5;
  localparam int PAYLOAD_W_DEF = 64;
  localparam int NFWD_DEF      = 3;
  localparam int CNT_W_DEF     = 32;

  // Producer port order: youngest first, so a lower index always holds the newer value.
  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;
endpackage

// File: rtl/id_bypass_stage_if.sv
// Upstream (IF->ID) and downstream (ID->EX) handshake bundle of the decode stage.
// master = fetch side / execute side environment, slave = the decode stage itself.
interface id_bypass_stage_if
  import id_bypass_stage_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int AW        = AW_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
);
  logic                 in_valid;
  logic                 in_allowin;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 in_src1_en;
  logic [AW-1:0]        in_src1_addr;
  logic                 in_src2_en;
  logic [AW-1:0]        in_src2_addr;

  logic                 out_valid;
  logic                 out_allowin;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [XLEN-1:0]      out_src1_val;
  logic [XLEN-1:0]      out_src2_val;

  modport master (
    output in_valid, in_payload, in_src1_en, in_src1_addr, in_src2_en, in_src2_addr,
    output out_allowin,
    input  in_allowin,
    input  out_valid, out_payload, out_src1_val, out_src2_val
  );

  modport slave (
    input  in_valid, in_payload, in_src1_en, in_src1_addr, in_src2_en, in_src2_addr,
    input  out_allowin,
    output in_allowin,
    output out_valid, out_payload, out_src1_val, out_src2_val
  );
endinterface

// File: rtl/id_bypass_stage_fwd_mux.sv
// One-operand resolver: priority match against producer ports, value select, hazard flag.
// ID_BYPASS_EN defined: forward youngest match; undefined: any match interlocks until write-back.
module id_fwd_mux #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3
) (
  input  logic                 src_en,
  input  logic [AW-1:0]        src_addr,
  input  logic [XLEN-1:0]      rf_rdata,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic [NFWD-1:0]      fwd_rdy,
  output logic [XLEN-1:0]      src_val,
  output logic                 hazard
);
  logic            live;
  logic [NFWD-1:0] match;

  // Register 0 is hardwired zero and never depends on a producer.
  assign live = src_en & (src_addr != '0);

  always_comb begin
    match = '0;
    for (int i = 0; i < NFWD; i++) begin
      match[i] = live & fwd_valid[i] & fwd_we[i] & (fwd_waddr[i*AW +: AW] == src_addr);
    end
  end

`ifdef ID_BYPASS_EN
  logic            hit;
  logic [XLEN-1:0] sel_data;
  logic            sel_rdy;

  // Walk oldest to youngest so the lowest-index match overwrites the rest.
  always_comb begin
    hit      = 1'b0;
    sel_data = rf_rdata;
    sel_rdy  = 1'b1;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit      = 1'b1;
        sel_data = fwd_wdata[i*XLEN +: XLEN];
        sel_rdy  = fwd_rdy[i];
      end
    end
  end

  assign src_val = live ? sel_data : '0;
  assign hazard  = hit & ~sel_rdy;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_wdata, fwd_rdy};

  assign src_val = live ? rf_rdata : '0;
  assign hazard  = |match;
`endif
endmodule

// File: rtl/id_bypass_stage.sv
// Decode pipeline slot: one held IF->ID entry, two resolved operands to EX, stall counter.
// Latency 1; holds while a source hazard exists or EX is not accepting. Option: ID_BYPASS_EN.
module id_bypass_stage
  import id_bypass_stage_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int AW        = AW_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int NFWD      = NFWD_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_bypass_stage_if.slave     io,
  input  logic                 flush,
  output logic [AW-1:0]        rf_raddr1,
  output logic [AW-1:0]        rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic [NFWD-1:0]      fwd_rdy,
  output logic [CNT_W-1:0]     stall_cnt
);
  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 src1_en_q, src1_en_d;
  logic [AW-1:0]        src1_addr_q, src1_addr_d;
  logic                 src2_en_q, src2_en_d;
  logic [AW-1:0]        src2_addr_q, src2_addr_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic hazard1, hazard2, hazard, ready_go, in_allowin;

  id_fwd_mux #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_mux1 (
    .src_en    (src1_en_q),
    .src_addr  (src1_addr_q),
    .rf_rdata  (rf_rdata1),
    .fwd_valid (fwd_valid),
    .fwd_we    (fwd_we),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .fwd_rdy   (fwd_rdy),
    .src_val   (io.out_src1_val),
    .hazard    (hazard1)
  );

  id_fwd_mux #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_mux2 (
    .src_en    (src2_en_q),
    .src_addr  (src2_addr_q),
    .rf_rdata  (rf_rdata2),
    .fwd_valid (fwd_valid),
    .fwd_we    (fwd_we),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .fwd_rdy   (fwd_rdy),
    .src_val   (io.out_src2_val),
    .hazard    (hazard2)
  );

  assign hazard     = hazard1 | hazard2;
  assign ready_go   = ~hazard;
  assign in_allowin = ~valid_q | (ready_go & io.out_allowin);

  assign io.in_allowin  = in_allowin;
  assign io.out_valid   = valid_q & ready_go & ~flush;
  assign io.out_payload = payload_q;
  assign rf_raddr1      = src1_addr_q;
  assign rf_raddr2      = src2_addr_q;
  assign stall_cnt      = stall_cnt_q;

  always_comb begin
    valid_d     = valid_q;
    payload_d   = payload_q;
    src1_en_d   = src1_en_q;
    src1_addr_d = src1_addr_q;
    src2_en_d   = src2_en_q;
    src2_addr_d = src2_addr_q;
    // Flush wins over a same-cycle capture: the incoming entry is dropped too.
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_allowin) begin
      valid_d = io.in_valid;
      if (io.in_valid) begin
        payload_d   = io.in_payload;
        src1_en_d   = io.in_src1_en;
        src1_addr_d = io.in_src1_addr;
        src2_en_d   = io.in_src2_en;
        src2_addr_d = io.in_src2_addr;
      end
    end
  end

  // Only true interlock cycles count; EX backpressure alone does not.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q & hazard & ~flush & (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      payload_q   <= '0;
      src1_en_q   <= 1'b0;
      src1_addr_q <= '0;
      src2_en_q   <= 1'b0;
      src2_addr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      payload_q   <= payload_d;
      src1_en_q   <= src1_en_d;
      src1_addr_q <= src1_addr_d;
      src2_en_q   <= src2_en_d;
      src2_addr_q <= src2_addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_id_bypass_stage.sv
// Directed bench for id_bypass_stage: driver pushes expected EX-side results, a negedge monitor
// pops and compares; expectations follow whichever ID_BYPASS_EN build is compiled.
module tb_id_bypass_stage;
  import id_bypass_stage_pkg::*;

`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] payload;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_valid, fwd_we, fwd_rdy;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic [31:0] stall_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_stall = 0;

  id_bypass_stage_if #(.XLEN(32), .AW(5), .PAYLOAD_W(64)) io ();

  id_bypass_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (io),
    .flush     (flush),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .fwd_valid (fwd_valid),
    .fwd_we    (fwd_we),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .fwd_rdy   (fwd_rdy),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    case (a)
      5'd3:    return 32'h30;
      5'd4:    return 32'h11;
      5'd5:    return 32'h22;
      5'd7:    return 32'h70;
      5'd9:    return 32'h99;
      default: return 32'hEE00_0000;
    endcase
  endfunction

  assign rf_rdata1 = rf_val(rf_raddr1);
  assign rf_rdata2 = rf_val(rf_raddr2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: payload %h with no entry expected", io.out_payload);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_payload", io.out_payload, e.payload);
        chk("out_src1_val", {32'h0, io.out_src1_val}, {32'h0, e.v1});
        chk("out_src2_val", {32'h0, io.out_src2_val}, {32'h0, e.v2});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int p, input logic [4:0] a, input logic [31:0] d, input logic r);
    fwd_valid[p]         = 1'b1;
    fwd_we[p]            = 1'b1;
    fwd_waddr[p*5 +: 5]  = a;
    fwd_wdata[p*32 +: 32] = d;
    fwd_rdy[p]           = r;
  endtask

  task automatic clr_fwd();
    fwd_valid = '0;
    fwd_we    = '0;
    fwd_waddr = '0;
    fwd_wdata = '0;
    fwd_rdy   = '0;
  endtask

  task automatic issue(input logic [63:0] p, input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    io.in_valid     = 1'b1;
    io.in_payload   = p;
    io.in_src1_en   = e1;
    io.in_src1_addr = a1;
    io.in_src2_en   = e2;
    io.in_src2_addr = a2;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d entries never left the stage, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    io.in_valid = 1'b0;
    io.in_payload = '0;
    io.in_src1_en = 1'b0;
    io.in_src1_addr = '0;
    io.in_src2_en = 1'b0;
    io.in_src2_addr = '0;
    io.out_allowin = 1'b1;
    clr_fwd();

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'h0, io.out_valid}, 64'h0);
    chk("rst_in_allowin", {63'h0, io.in_allowin}, 64'h1);
    chk("rst_stall_cnt", {32'h0, stall_cnt}, 64'h0);
    rst_n = 1'b1;
    step();

    // No hazard
    issue(64'hA000_0000_0000_0001, 1'b1, 5'd4, 1'b1, 5'd5);
    exp_q.push_back('{64'hA000_0000_0000_0001, 32'h11, 32'h22});
    step(); io.in_valid = 1'b0;
    step();
    wait_drain("no_hazard");
    chk("stall_no_hazard", {32'h0, stall_cnt}, {32'h0, exp_stall});

    // Priority: port 0 beats port 2
    set_fwd(FWD_EX, 5'd7, 32'hA, 1'b1);
    set_fwd(FWD_WB, 5'd7, 32'hC, 1'b1);
    issue(64'hA000_0000_0000_0002, 1'b1, 5'd7, 1'b0, 5'd0);
    exp_q.push_back('{64'hA000_0000_0000_0002, BYP ? 32'hA : 32'h70, 32'h0});
    step(); io.in_valid = 1'b0;
    step(); clr_fwd();
    exp_stall += BYP ? 32'd0 : 32'd1;
    wait_drain("priority");
    chk("stall_priority", {32'h0, stall_cnt}, {32'h0, exp_stall});

    // Load-use on source 2
    set_fwd(FWD_EX, 5'd3, 32'h55, 1'b0);
    issue(64'hA000_0000_0000_0003, 1'b0, 5'd0, 1'b1, 5'd3);
    exp_q.push_back('{64'hA000_0000_0000_0003, 32'h0, BYP ? 32'h55 : 32'h30});
    step(); io.in_valid = 1'b0;
    @(negedge clk);
    chk("loaduse_in_allowin", {63'h0, io.in_allowin}, 64'h0);
    chk("loaduse_out_valid", {63'h0, io.out_valid}, 64'h0);
    step(); fwd_rdy[FWD_EX] = 1'b1;
    step(); clr_fwd();
    exp_stall += BYP ? 32'd1 : 32'd2;
    wait_drain("loaduse");
    chk("stall_loaduse", {32'h0, stall_cnt}, {32'h0, exp_stall});

    // r0 source and disabled source never hazard
    set_fwd(FWD_EX, 5'd0, 32'hFF, 1'b1);
    set_fwd(FWD_MEM, 5'd5, 32'h77, 1'b0);
    issue(64'hA000_0000_0000_0004, 1'b1, 5'd0, 1'b0, 5'd5);
    exp_q.push_back('{64'hA000_0000_0000_0004, 32'h0, 32'h0});
    step(); io.in_valid = 1'b0;
    step(); clr_fwd();
    wait_drain("r0_disabled");
    chk("stall_r0_disabled", {32'h0, stall_cnt}, {32'h0, exp_stall});

    // Flush while stalled, then flush against a capture into an empty stage
    set_fwd(FWD_EX, 5'd3, 32'h66, 1'b0);
    issue(64'hA000_0000_0000_0005, 1'b1, 5'd3, 1'b0, 5'd0);
    step(); io.in_valid = 1'b0;
    step();
    flush = 1'b1;
    issue(64'hA000_0000_0000_0006, 1'b1, 5'd4, 1'b1, 5'd5);
    @(negedge clk);
    chk("flush_out_valid", {63'h0, io.out_valid}, 64'h0);
    step();
    @(negedge clk);
    chk("flush_in_allowin", {63'h0, io.in_allowin}, 64'h1);
    step();
    flush = 1'b0; io.in_valid = 1'b0; clr_fwd();
    @(negedge clk);
    chk("flush_dropped", {63'h0, io.out_valid}, 64'h0);
    exp_stall += 32'd1;
    step();
    chk("stall_flush", {32'h0, stall_cnt}, {32'h0, exp_stall});

    // Producer walks EX -> MEM -> WB -> retired
    set_fwd(FWD_EX, 5'd9, 32'h9A, 1'b1);
    issue(64'hA000_0000_0000_0007, 1'b1, 5'd9, 1'b0, 5'd0);
    exp_q.push_back('{64'hA000_0000_0000_0007, BYP ? 32'h9A : 32'h99, 32'h0});
    step(); io.in_valid = 1'b0;
    step(); clr_fwd(); set_fwd(FWD_MEM, 5'd9, 32'h9A, 1'b1);
    step(); clr_fwd(); set_fwd(FWD_WB, 5'd9, 32'h9A, 1'b1);
    step(); clr_fwd();
    exp_stall += BYP ? 32'd0 : 32'd3;
    wait_drain("walk");
    chk("stall_walk", {32'h0, stall_cnt}, {32'h0, exp_stall});

    // EX backpressure without hazard
    io.out_allowin = 1'b0;
    issue(64'hA000_0000_0000_0008, 1'b1, 5'd4, 1'b0, 5'd0);
    exp_q.push_back('{64'hA000_0000_0000_0008, 32'h11, 32'h0});
    step(); io.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_in_allowin", {63'h0, io.in_allowin}, 64'h0);
      chk("bp_out_valid", {63'h0, io.out_valid}, 64'h1);
      step();
    end
    io.out_allowin = 1'b1;
    wait_drain("backpressure");
    chk("stall_backpressure", {32'h0, stall_cnt}, {32'h0, exp_stall});

    // Back-to-back entries
    issue(64'hA000_0000_0000_0009, 1'b1, 5'd4, 1'b1, 5'd5);
    exp_q.push_back('{64'hA000_0000_0000_0009, 32'h11, 32'h22});
    step();
    issue(64'hA000_0000_0000_000A, 1'b1, 5'd7, 1'b1, 5'd3);
    exp_q.push_back('{64'hA000_0000_0000_000A, 32'h70, 32'h30});
    @(negedge clk);
    chk("b2b_in_allowin", {63'h0, io.in_allowin}, 64'h1);
    step(); io.in_valid = 1'b0;
    wait_drain("back_to_back");

    // Async reset in the middle of a stall
    set_fwd(FWD_EX, 5'd3, 32'h44, 1'b0);
    issue(64'hA000_0000_0000_000B, 1'b1, 5'd3, 1'b0, 5'd0);
    step(); io.in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'h0, io.out_valid}, 64'h0);
    chk("arst_stall_cnt", {32'h0, stall_cnt}, 64'h0);
    chk("arst_in_allowin", {63'h0, io.in_allowin}, 64'h1);
    clr_fwd();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
